// File: rtl/ball_launcher_if.sv
// Signal bundle between the angle/power stage, VGA mixer and the ball launcher.
// The launcher takes the slave side; the driver of frame and pixel timing takes the master side.
interface ball_launcher_if;
  logic       tick;
  logic       launch;
  logic [2:0] Vel;
  logic [4:0] Ang;
  logic [9:0] xCount;
  logic [9:0] yCount;
  logic [9:0] ballX;
  logic [8:0] ballY;
  logic       ball;
  logic       busy;
  logic       landed;

  modport master (
    output tick, launch, Vel, Ang, xCount, yCount,
    input  ballX, ballY, ball, busy, landed
  );

  modport slave (
    input  tick, launch, Vel, Ang, xCount, yCount,
    output ballX, ballY, ball, busy, landed
  );
endinterface

// File: rtl/ball_launcher.sv
// Flies a ball along a gravity trajectory after a button press and flags the ball's pixels.
// Position and velocity are held in 1/16-pixel fixed point and advance once per frame tick.
module ball_launcher #(
  parameter int START_X    = 42,
  parameter int START_Y    = 425,
  parameter int GROUND_Y   = 430,
  parameter int X_MAX      = 639,
  parameter int GRAVITY    = 1,
  parameter int BALL_SIZE  = 6,
  parameter int HOLD_TICKS = 120
) (
  input  logic           clk,
  input  logic           rst,
  ball_launcher_if.slave bus
);

  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic        [13:0] X_START_FP  = 14'(START_X * 16);
  localparam logic        [13:0] X_MAX_FP    = 14'(X_MAX * 16);
  localparam logic signed [15:0] Y_START_FP  = 16'(START_Y * 16);
  localparam logic signed [15:0] Y_GROUND_FP = 16'(GROUND_Y * 16);
  localparam logic signed [15:0] GRAV_FP     = 16'(GRAVITY);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLY, S_LANDED} state_t;

  state_t r_state, w_state_next;

  logic r_launch_meta, r_launch_sync, r_launch_prev;
  logic w_trigger;

  logic        [13:0] r_x,  w_x_next;
  logic signed [15:0] r_y,  w_y_next;
  logic        [7:0]  r_vx, w_vx_next;
  logic signed [15:0] r_vy, w_vy_next;
  logic      [HW-1:0] r_hold, w_hold_next;
  logic               r_ball;

  logic [2:0] w_vel_c;
  logic [4:0] w_ang_c;
  logic [3:0] w_sin, w_cos;
  logic [7:0] w_vp1, w_vx_load, w_vy_load;

  logic        [13:0] w_x_add;
  logic signed [15:0] w_y_sub;
  logic               w_x_over, w_y_ground;

  logic [9:0] w_bx, w_by, w_hit_x, w_hit_y;
  logic       w_hit;

  function automatic logic [3:0] sin_lut(input logic [4:0] a);
    case (a)
      5'd0:           sin_lut = 4'd0;
      5'd1:           sin_lut = 4'd1;
      5'd2, 5'd3:     sin_lut = 4'd2;
      5'd4:           sin_lut = 4'd3;
      5'd5, 5'd6:     sin_lut = 4'd4;
      5'd7:           sin_lut = 4'd5;
      5'd8, 5'd9:     sin_lut = 4'd6;
      5'd10, 5'd11,
      5'd12:          sin_lut = 4'd7;
      default:        sin_lut = 4'd8;
    endcase
  endfunction

  // The button idles high; sync flops reset high so a reset never leaves a falling edge pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_launch_meta <= 1'b1;
      r_launch_sync <= 1'b1;
      r_launch_prev <= 1'b1;
    end else begin
      r_launch_meta <= bus.launch;
      r_launch_sync <= r_launch_meta;
      r_launch_prev <= r_launch_sync;
    end
  end

  assign w_trigger = r_launch_prev & ~r_launch_sync;

  assign w_vel_c   = (bus.Vel > 3'd5)  ? 3'd5  : bus.Vel;
  assign w_ang_c   = (bus.Ang > 5'd16) ? 5'd16 : bus.Ang;
  assign w_sin     = sin_lut(w_ang_c);
  assign w_cos     = sin_lut(5'd16 - w_ang_c);
  assign w_vp1     = {5'd0, w_vel_c} + 8'd1;
  assign w_vx_load = ({4'd0, w_cos} * w_vp1) << 1;
  assign w_vy_load = ({4'd0, w_sin} * w_vp1) << 1;

  assign w_x_add    = r_x + {6'd0, r_vx};
  assign w_y_sub    = r_y - r_vy;
  assign w_x_over   = (w_x_add[13:4] > 10'(X_MAX));
  assign w_y_ground = (w_y_sub >= Y_GROUND_FP);

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_y_next     = r_y;
    w_vx_next    = r_vx;
    w_vy_next    = r_vy;
    w_hold_next  = r_hold;
    bus.busy     = 1'b0;
    bus.landed   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_x_next = X_START_FP;
        w_y_next = Y_START_FP;
        if (w_trigger) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        bus.busy     = 1'b1;
        w_vx_next    = w_vx_load;
        w_vy_next    = $signed({8'd0, w_vy_load});
        w_state_next = S_FLY;
      end
      S_FLY: begin
        bus.busy = 1'b1;
        if (bus.tick) begin
          w_x_next  = w_x_add;
          w_y_next  = w_y_sub;
          w_vy_next = r_vy - GRAV_FP;
          // Ground and right-edge clamps are independent so a corner landing clamps both.
          if (w_y_ground) w_y_next = Y_GROUND_FP;
          if (w_x_over)   w_x_next = X_MAX_FP;
          if (w_y_ground || w_x_over) begin
            w_state_next = S_LANDED;
            w_hold_next  = '0;
          end
        end
      end
      S_LANDED: begin
        bus.landed = 1'b1;
        if (bus.tick) begin
          if (r_hold == HW'(HOLD_TICKS - 1)) begin
            w_hold_next  = '0;
            w_x_next     = X_START_FP;
            w_y_next     = Y_START_FP;
            w_state_next = S_IDLE;
          end else begin
            w_hold_next = r_hold + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= X_START_FP;
      r_y     <= Y_START_FP;
      r_vx    <= '0;
      r_vy    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_vx    <= w_vx_next;
      r_vy    <= w_vy_next;
      r_hold  <= w_hold_next;
    end
  end

  // y never goes negative and never exceeds the ground line, so bits 12:4 are the whole pixel row.
  assign w_bx      = r_x[13:4];
  assign w_by      = {1'b0, r_y[12:4]};
  assign bus.ballX = w_bx;
  assign bus.ballY = r_y[12:4];

  assign w_hit_x = w_bx + 10'(BALL_SIZE);
  assign w_hit_y = w_by + 10'(BALL_SIZE);
  assign w_hit   = (bus.xCount >= w_bx) && (bus.xCount < w_hit_x) &&
                   (bus.yCount >= w_by) && (bus.yCount < w_hit_y);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ball <= 1'b0;
    else     r_ball <= w_hit;
  end

  assign bus.ball = r_ball;

endmodule

// File: tb/tb_ball_launcher.sv
// Directed bench for ball_launcher: trajectories, clamps, trigger rules, re-arm,
// reset mid-flight and the registered pixel flag, against hand-computed values.
module tb_ball_launcher;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  ball_launcher_if bl_if ();

  ball_launcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bl_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bl_if.tick = 1'b1;
      @(negedge clk);
      bl_if.tick = 1'b0;
      @(negedge clk);
    end
  endtask

  // Four cycles low then release; the block is in FLY by the time this returns.
  task automatic press();
    bl_if.launch = 1'b0;
    repeat (4) @(negedge clk);
    bl_if.launch = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pixel(input int x, input int y, input logic exp, input string tag);
    bl_if.xCount = 10'(x);
    bl_if.yCount = 10'(y);
    @(negedge clk);
    check_vec(tag, 32'(bl_if.ball), 32'(exp));
  endtask

  initial begin
    rst          = 1'b1;
    bl_if.tick   = 1'b0;
    bl_if.launch = 1'b1;
    bl_if.Vel    = 3'd0;
    bl_if.Ang    = 5'd0;
    bl_if.xCount = 10'd0;
    bl_if.yCount = 10'd0;
    repeat (3) @(negedge clk);

    check_vec("rst_ballX",  32'(bl_if.ballX),  32'd42);
    check_vec("rst_ballY",  32'(bl_if.ballY),  32'd425);
    check_vec("rst_busy",   32'(bl_if.busy),   32'd0);
    check_vec("rst_landed", 32'(bl_if.landed), 32'd0);
    check_vec("rst_ball",   32'(bl_if.ball),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    pixel(42, 425, 1'b1, "pix_origin");
    pixel(48, 425, 1'b0, "pix_right_out");
    pixel(47, 430, 1'b1, "pix_corner_in");
    pixel(42, 431, 1'b0, "pix_below_out");
    pixel(41, 425, 1'b0, "pix_left_out");

    // Flat shot with the button held low for ~1000 cycles.
    bl_if.Ang    = 5'd0;
    bl_if.Vel    = 3'd0;
    bl_if.launch = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("load_busy", 32'(bl_if.busy), 32'd1);
    bl_if.tick = 1'b1;
    @(negedge clk);
    bl_if.tick = 1'b0;
    check_vec("load_tick_ignored_x", 32'(bl_if.ballX), 32'd42);
    check_vec("load_tick_ignored_y", 32'(bl_if.ballY), 32'd425);
    bl_if.Vel = 3'd5;
    bl_if.Ang = 5'd16;
    do_ticks(13);
    check_vec("flat_t13_y",    32'(bl_if.ballY),  32'd429);
    check_vec("flat_t13_busy", 32'(bl_if.busy),   32'd1);
    do_ticks(1);
    check_vec("flat_land_x",      32'(bl_if.ballX),  32'd56);
    check_vec("flat_land_y",      32'(bl_if.ballY),  32'd430);
    check_vec("flat_land_landed", 32'(bl_if.landed), 32'd1);
    check_vec("flat_land_busy",   32'(bl_if.busy),   32'd0);
    do_ticks(119);
    check_vec("hold_119_landed", 32'(bl_if.landed), 32'd1);
    do_ticks(1);
    check_vec("rearm_landed", 32'(bl_if.landed), 32'd0);
    check_vec("rearm_busy",   32'(bl_if.busy),   32'd0);
    check_vec("rearm_x",      32'(bl_if.ballX),  32'd42);
    check_vec("rearm_y",      32'(bl_if.ballY),  32'd425);
    repeat (700) @(negedge clk);
    check_vec("held_no_retrigger", 32'(bl_if.busy), 32'd0);
    bl_if.launch = 1'b1;
    repeat (4) @(negedge clk);
    check_vec("release_no_trigger", 32'(bl_if.busy), 32'd0);

    // Vertical shot from out-of-range indices, with a second press mid-flight.
    bl_if.Ang = 5'd31;
    bl_if.Vel = 3'd7;
    press();
    check_vec("vert_busy", 32'(bl_if.busy), 32'd1);
    do_ticks(50);
    press();
    check_vec("vert_repress_busy", 32'(bl_if.busy), 32'd1);
    do_ticks(46);
    check_vec("vert_apex_y", 32'(bl_if.ballY), 32'd134);
    check_vec("vert_apex_x", 32'(bl_if.ballX), 32'd42);
    do_ticks(97);
    check_vec("vert_t193_y",    32'(bl_if.ballY), 32'd425);
    check_vec("vert_t193_busy", 32'(bl_if.busy),  32'd1);
    do_ticks(1);
    check_vec("vert_land_y",      32'(bl_if.ballY),  32'd430);
    check_vec("vert_land_x",      32'(bl_if.ballX),  32'd42);
    check_vec("vert_land_landed", 32'(bl_if.landed), 32'd1);
    do_ticks(120);
    check_vec("vert_rearm_busy", 32'(bl_if.busy),   32'd0);
    check_vec("vert_rearm_land", 32'(bl_if.landed), 32'd0);

    // Right-edge clamp.
    bl_if.Ang = 5'd8;
    bl_if.Vel = 3'd5;
    press();
    do_ticks(132);
    check_vec("edge_t132_x",    32'(bl_if.ballX), 32'd636);
    check_vec("edge_t132_busy", 32'(bl_if.busy),  32'd1);
    do_ticks(1);
    check_vec("edge_clamp_x",      32'(bl_if.ballX),  32'd639);
    check_vec("edge_clamp_y",      32'(bl_if.ballY),  32'd375);
    check_vec("edge_landed",       32'(bl_if.landed), 32'd1);
    check_vec("edge_busy",         32'(bl_if.busy),   32'd0);
    do_ticks(120);
    check_vec("edge_rearm_busy", 32'(bl_if.busy), 32'd0);

    // Reset 50 ticks into the same trajectory.
    press();
    do_ticks(50);
    check_vec("mid_t50_x", 32'(bl_if.ballX), 32'd267);
    check_vec("mid_t50_y", 32'(bl_if.ballY), 32'd276);
    rst = 1'b1;
    #1;
    check_vec("mid_rst_x",    32'(bl_if.ballX), 32'd42);
    check_vec("mid_rst_y",    32'(bl_if.ballY), 32'd425);
    check_vec("mid_rst_busy", 32'(bl_if.busy),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_vec("post_rst_idle", 32'(bl_if.busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
